// File: rtl/rv32_types.sv
// Shared RV32 types for the multi-cycle M-extension sequencer: op/state encodings and special-case constants.
package rv32_types;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    MC_DIV  = 2'd0,
    MC_DIVU = 2'd1,
    MC_REM  = 2'd2,
    MC_REMU = 2'd3
  } mc_op_t;

  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_ISSUE = 2'd1,
    MC_WAIT  = 2'd2,
    MC_DONE  = 2'd3
  } mc_state_t;

  typedef struct packed {
    logic [XLEN-1:0] quot;
    logic [XLEN-1:0] rem;
  } mc_result_t;

  localparam logic [XLEN-1:0] MC_DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] MC_OVF_QUOT  = 32'h8000_0000;
  localparam logic [XLEN-1:0] MC_INT_MIN   = 32'h8000_0000;
  localparam logic [XLEN-1:0] MC_NEG_ONE   = 32'hFFFF_FFFF;

  function automatic logic mc_is_signed(input mc_op_t op);
    return (op == MC_DIV) || (op == MC_REM);
  endfunction

  function automatic logic mc_sel_rem(input mc_op_t op);
    return (op == MC_REM) || (op == MC_REMU);
  endfunction

endpackage

// File: rtl/rv32_div_special.sv
// Combinational detection of divide-by-zero and signed overflow, with the architectural fast-path result.
module rv32_div_special
  import rv32_types::*;
(
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            special_c,
  output logic [XLEN-1:0] data_c
);

  mc_op_t     op_e;
  logic       div0;
  logic       ovf;
  mc_result_t res;

  assign op_e = mc_op_t'(op);

  always_comb begin
    div0 = (op2 == '0);
    ovf  = mc_is_signed(op_e) && (op1 == MC_INT_MIN) && (op2 == MC_NEG_ONE);
    res  = '0;
    if (div0) begin
      res.quot = MC_DIV0_QUOT;
      res.rem  = op1;
    end else if (ovf) begin
      res.quot = MC_OVF_QUOT;
      res.rem  = '0;
    end
    special_c = div0 | ovf;
    data_c    = mc_sel_rem(op_e) ? res.rem : res.quot;
  end

endmodule

// File: rtl/rv32_mc_exec_ctrl.sv
// Multi-cycle DIV/REM sequencer: stalls exec while an external divider runs and resolves special cases inline.
// Optional last-result cache is enabled by defining RV32_MC_RESULT_CACHE_EN.
module rv32_mc_exec_ctrl
  import rv32_types::*;
#(
  parameter int unsigned UNIT_TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_op1,
  input  logic [XLEN-1:0] req_op2,
  input  logic            flush,
  input  logic            res_ack,
  output logic            stall,
  output logic            res_valid,
  output logic [XLEN-1:0] res_data,
  output logic            unit_start,
  output logic            unit_abort,
  output logic            unit_signed,
  output logic [XLEN-1:0] unit_op1,
  output logic [XLEN-1:0] unit_op2,
  input  logic            unit_done,
  input  logic [XLEN-1:0] unit_quot,
  input  logic [XLEN-1:0] unit_rem,
  output logic            timeout_err
);

  localparam int unsigned      CNT_W   = (UNIT_TIMEOUT == 0) ? 1 : $clog2(UNIT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(UNIT_TIMEOUT);

  mc_state_t       state;
  logic [CNT_W-1:0] wait_cnt;
  logic            sel_rem;
  mc_op_t          op;
  logic            req_signed;
  logic            req_rem;
  logic            special_c;
  logic [XLEN-1:0] special_data_c;
  logic            cache_hit_c;
  logic [XLEN-1:0] cache_data_c;

  assign op         = mc_op_t'(req_op);
  assign req_signed = mc_is_signed(op);
  assign req_rem    = mc_sel_rem(op);
  assign stall      = req_valid & ~res_valid;

  rv32_div_special u_special (
    .op        (req_op),
    .op1       (req_op1),
    .op2       (req_op2),
    .special_c (special_c),
    .data_c    (special_data_c)
  );

`ifdef RV32_MC_RESULT_CACHE_EN
  logic            cache_valid;
  logic            cache_signed;
  logic [XLEN-1:0] cache_op1;
  logic [XLEN-1:0] cache_op2;
  logic [XLEN-1:0] cache_quot;
  logic [XLEN-1:0] cache_rem;

  // Only a divider completion that flush did not kill refreshes the entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cache_valid  <= 1'b0;
      cache_signed <= 1'b0;
      cache_op1    <= '0;
      cache_op2    <= '0;
      cache_quot   <= '0;
      cache_rem    <= '0;
    end else if ((state == MC_WAIT) && unit_done && !flush) begin
      cache_valid  <= 1'b1;
      cache_signed <= unit_signed;
      cache_op1    <= unit_op1;
      cache_op2    <= unit_op2;
      cache_quot   <= unit_quot;
      cache_rem    <= unit_rem;
    end
  end

  assign cache_hit_c  = cache_valid && (cache_op1 == req_op1) && (cache_op2 == req_op2) &&
                        (cache_signed == req_signed);
  assign cache_data_c = req_rem ? cache_rem : cache_quot;
`else
  assign cache_hit_c  = 1'b0;
  assign cache_data_c = '0;
`endif

  // Sequencer FSM; flush overrides done, timeout and ack in every state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= MC_IDLE;
      wait_cnt    <= '0;
      sel_rem     <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      unit_start  <= 1'b0;
      unit_abort  <= 1'b0;
      unit_signed <= 1'b0;
      unit_op1    <= '0;
      unit_op2    <= '0;
      timeout_err <= 1'b0;
    end else begin
      unit_start <= 1'b0;
      unit_abort <= 1'b0;
      if (flush) begin
        state      <= MC_IDLE;
        res_valid  <= 1'b0;
        unit_abort <= (state == MC_ISSUE) || (state == MC_WAIT);
      end else begin
        case (state)
          MC_IDLE: begin
            if (req_valid) begin
              if (special_c) begin
                state     <= MC_DONE;
                res_valid <= 1'b1;
                res_data  <= special_data_c;
              end else if (cache_hit_c) begin
                state     <= MC_DONE;
                res_valid <= 1'b1;
                res_data  <= cache_data_c;
              end else begin
                state       <= MC_ISSUE;
                unit_start  <= 1'b1;
                unit_signed <= req_signed;
                unit_op1    <= req_op1;
                unit_op2    <= req_op2;
                sel_rem     <= req_rem;
              end
            end
          end
          MC_ISSUE: begin
            state    <= MC_WAIT;
            wait_cnt <= '0;
          end
          MC_WAIT: begin
            if (unit_done) begin
              state     <= MC_DONE;
              res_valid <= 1'b1;
              res_data  <= sel_rem ? unit_rem : unit_quot;
            end else if (wait_cnt == CNT_MAX) begin
              state       <= MC_DONE;
              res_valid   <= 1'b1;
              res_data    <= '0;
              unit_abort  <= 1'b1;
              timeout_err <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + CNT_W'(1);
            end
          end
          MC_DONE: begin
            if (res_ack) begin
              state     <= MC_IDLE;
              res_valid <= 1'b0;
            end
          end
          default: state <= MC_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rv32_mc_exec_ctrl.sv
// Randomized self-checking bench for rv32_mc_exec_ctrl; the bench also plays the iterative divider.
module tb_rv32_mc_exec_ctrl;

  localparam int unsigned TMO = 4;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_op1;
  logic [31:0] req_op2;
  logic        flush;
  logic        res_ack;
  logic        stall;
  logic        res_valid;
  logic [31:0] res_data;
  logic        unit_start;
  logic        unit_abort;
  logic        unit_signed;
  logic [31:0] unit_op1;
  logic [31:0] unit_op2;
  logic        unit_done;
  logic [31:0] unit_quot;
  logic [31:0] unit_rem;
  logic        timeout_err;

  int checks   = 0;
  int failures = 0;
  bit exp_terr = 1'b0;

`ifdef RV32_MC_RESULT_CACHE_EN
  bit          m_cv = 1'b0;
  bit          m_cs = 1'b0;
  logic [31:0] m_ca = '0;
  logic [31:0] m_cb = '0;
`endif

  rv32_mc_exec_ctrl #(.UNIT_TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_op      (req_op),
    .req_op1     (req_op1),
    .req_op2     (req_op2),
    .flush       (flush),
    .res_ack     (res_ack),
    .stall       (stall),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .unit_start  (unit_start),
    .unit_abort  (unit_abort),
    .unit_signed (unit_signed),
    .unit_op1    (unit_op1),
    .unit_op2    (unit_op2),
    .unit_done   (unit_done),
    .unit_quot   (unit_quot),
    .unit_rem    (unit_rem),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural RV32M results: special cases first, otherwise truncating division.
  function automatic void ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r, output bit special);
    bit sgn;
    sgn = (op == 2'd0) || (op == 2'd2);
    special = 1'b1;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      special = 1'b0;
      if (sgn) begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end else begin
        q = a / b;
        r = a % b;
      end
    end
  endfunction

  function automatic bit model_hit(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    bit h;
    h = 1'b0;
`ifdef RV32_MC_RESULT_CACHE_EN
    h = m_cv && (a == m_ca) && (b == m_cb) && (sgn == m_cs);
`else
    h = (a == b) && sgn && 1'b0;
`endif
    return h;
  endfunction

  function automatic void model_fill(input logic [31:0] a, input logic [31:0] b, input bit sgn);
`ifdef RV32_MC_RESULT_CACHE_EN
    m_cv = 1'b1;
    m_ca = a;
    m_cb = b;
    m_cs = sgn;
`else
    if (a == b && sgn) checks = checks + 0;
`endif
  endfunction

  task automatic idle_cycles(input int n);
    logic [4:0] obs;
    logic [4:0] expc;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      flush     = 1'b0;
      res_ack   = 1'b0;
      unit_done = 1'($urandom_range(0, 1));
      unit_quot = $urandom;
      unit_rem  = $urandom;
      @(negedge clk);
      obs  = {stall, res_valid, unit_start, unit_abort, timeout_err};
      expc = {1'b0, 1'b0, 1'b0, 1'b0, exp_terr};
      checks++;
      if (obs !== expc) begin
        failures++;
        $display("FAIL idle_ctrl got=%b want=%b", obs, expc);
      end
    end
  endtask

  // One full transaction: request, optional divider latency n, d cycles of withheld ack, then gap idle cycles.
  task automatic drive_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int n, input int d, input int gap);
    logic [31:0] q, r, expd;
    bit          spec, fast, sgn;
    int          rc;
    logic [4:0]  obs, expc;
    sgn = !op[0];
    ref_op(op, a, b, q, r, spec);
    expd = op[1] ? r : q;
    fast = spec || model_hit(a, b, sgn);
    rc   = fast ? 1 : 2 + n;
    for (int c = 0; c <= rc + d; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_op    = op;
      req_op1   = a;
      req_op2   = b;
      flush     = 1'b0;
      res_ack   = (c == rc + d);
      if (!fast && c == 1 + n) begin
        unit_done = 1'b1;
        unit_quot = q;
        unit_rem  = r;
      end else if (fast || c <= 1 || c >= rc) begin
        unit_done = 1'($urandom_range(0, 1));
        unit_quot = $urandom;
        unit_rem  = $urandom;
      end else begin
        unit_done = 1'b0;
      end
      @(negedge clk);
      obs  = {stall, res_valid, unit_start, unit_abort, timeout_err};
      expc = {c < rc, c >= rc, !fast && c == 1, 1'b0, exp_terr};
      checks++;
      if (obs !== expc) begin
        failures++;
        $display("FAIL op_ctrl op=%0d a=%h b=%h cyc=%0d got=%b want=%b", op, a, b, c, obs, expc);
      end
      if (c >= rc) begin
        checks++;
        if (res_data !== expd) begin
          failures++;
          $display("FAIL op_data op=%0d a=%h b=%h cyc=%0d got=%h want=%h", op, a, b, c, res_data, expd);
        end
      end
      if (!fast && c == 1) begin
        checks++;
        if ({unit_signed, unit_op1, unit_op2} !== {sgn, a, b}) begin
          failures++;
          $display("FAIL unit_operands got=%b/%h/%h want=%b/%h/%h", unit_signed, unit_op1, unit_op2, sgn, a, b);
        end
      end
    end
    if (!fast) model_fill(a, b, sgn);
    idle_cycles(gap);
  endtask

  task automatic rand_operands(output logic [1:0] op, output logic [31:0] a, output logic [31:0] b);
    int k;
    op = 2'($urandom_range(0, 3));
    k  = int'($urandom_range(0, 9));
    a  = $urandom;
    b  = (k < 5) ? 32'($urandom_range(1, 50)) : $urandom;
    if (k == 0) b = 32'd0;
    if (k == 1) begin
      a = 32'h8000_0000;
      b = 32'hFFFF_FFFF;
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'd0;
    req_op1   = '0;
    req_op2   = '0;
    flush     = 1'b0;
    res_ack   = 1'b0;
    unit_done = 1'b0;
    unit_quot = '0;
    unit_rem  = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({stall, res_valid, unit_start, unit_abort, unit_signed, timeout_err, res_data, unit_op1, unit_op2} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b%b%b%b%b%b %h %h %h", stall, res_valid, unit_start, unit_abort,
               unit_signed, timeout_err, res_data, unit_op1, unit_op2);
    end
    reset = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_fast_path();
    drive_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 1);
    drive_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 1);
    drive_op(2'd3, 32'd55, 32'd0, 1, 0, 1);
    drive_op(2'd1, 32'd55, 32'd0, 1, 0, 1);
    drive_op(2'd0, 32'hFFFF_FFEC, 32'd0, 1, 1, 1);
  endtask

  task automatic test_unit_path();
    logic [1:0]  op;
    logic [31:0] a, b;
    drive_op(2'd1, 32'd100, 32'd7, 3, 0, 1);
    drive_op(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 1);
    drive_op(2'd3, 32'hDEAD_BEEF, 32'd1000, int'(TMO), 0, 1);
    for (int i = 0; i < 24; i++) begin
      rand_operands(op, a, b);
      drive_op(op, a, b, int'($urandom_range(1, TMO)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_ack_hold();
    drive_op(2'd2, 32'd1000, 32'd7, 2, 3, 1);
    drive_op(2'd1, 32'd9, 32'd0, 1, 3, 1);
  endtask

  task automatic test_back_to_back();
    logic [1:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      rand_operands(op, a, b);
      drive_op(op, a, b, int'($urandom_range(1, TMO)), int'($urandom_range(0, 1)), 0);
    end
    idle_cycles(1);
  endtask

  // Flush at cycle f of an issued op: 0=IDLE, 1=ISSUE, 2..1+n=WAIT (1+n coincides with done), later=DONE.
  task automatic flush_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int n, input int f);
    logic [31:0] q, r, expd;
    bit          spec, rv;
    logic [4:0]  obs, expc;
    ref_op(op, a, b, q, r, spec);
    expd = op[1] ? r : q;
    for (int c = 0; c <= f + 2; c++) begin
      @(posedge clk); #1;
      req_valid = (c <= f);
      req_op    = op;
      req_op1   = a;
      req_op2   = b;
      flush     = (c == f);
      res_ack   = (c == f);
      unit_done = (c == 1 + n);
      unit_quot = q;
      unit_rem  = r;
      @(negedge clk);
      rv   = (c >= 2 + n) && (c <= f);
      obs  = {stall, res_valid, unit_start, unit_abort, timeout_err};
      expc = {(c <= f) && !rv, rv, (c == 1) && (f >= 1), (c == f + 1) && (f >= 1) && (f <= 1 + n), exp_terr};
      checks++;
      if (obs !== expc) begin
        failures++;
        $display("FAIL flush_ctrl n=%0d f=%0d cyc=%0d got=%b want=%b", n, f, c, obs, expc);
      end
      if (rv) begin
        checks++;
        if (res_data !== expd) begin
          failures++;
          $display("FAIL flush_data cyc=%0d got=%h want=%h", c, res_data, expd);
        end
      end
    end
    if (f >= 2 + n) model_fill(a, b, !op[0]);
  endtask

  task automatic test_flush();
    logic [1:0]  op;
    logic [31:0] a, b;
    int          n;
    flush_op(2'd1, 32'd77, 32'd5, 2, 3);
    flush_op(2'd0, 32'd77, 32'd6, 2, 1);
    flush_op(2'd2, 32'd78, 32'd6, 1, 0);
    for (int i = 0; i < 12; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = 32'($urandom_range(1, 1000));
      if (model_hit(a, b, !op[0])) a = a ^ 32'd1;
      n  = int'($urandom_range(1, TMO));
      flush_op(op, a, b, n, int'($urandom_range(0, 3 + n)));
    end
    idle_cycles(2);
    drive_op(2'd1, 32'd100, 32'd7, 1, 0, 1);
  endtask

`ifdef RV32_MC_RESULT_CACHE_EN
  task automatic test_cache();
    drive_op(2'd0, 32'hFFFF_FFEC, 32'd6, 3, 0, 1);
    drive_op(2'd2, 32'hFFFF_FFEC, 32'd6, 3, 0, 1);
    drive_op(2'd3, 32'hFFFF_FFEC, 32'd6, 2, 0, 1);
    drive_op(2'd1, 32'hFFFF_FFEC, 32'd6, 2, 0, 1);
  endtask
`endif

  task automatic test_timeout();
    logic [31:0] a;
    logic [4:0]  obs, expc;
    int          first_wait, rc;
    a = $urandom | 32'h1000_0000;
    first_wait = 2;
    rc = first_wait + int'(TMO) + 1;
    for (int c = 0; c <= rc + 1; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_op    = 2'd1;
      req_op1   = a;
      req_op2   = 32'd3;
      flush     = 1'b0;
      res_ack   = (c == rc + 1);
      unit_done = 1'b0;
      @(negedge clk);
      obs  = {stall, res_valid, unit_start, unit_abort, timeout_err};
      expc = {c < rc, c >= rc, c == 1, c == rc, exp_terr || (c >= rc)};
      checks++;
      if (obs !== expc) begin
        failures++;
        $display("FAIL timeout_ctrl cyc=%0d got=%b want=%b", c, obs, expc);
      end
      if (c >= rc) begin
        checks++;
        if (res_data !== 32'd0) begin
          failures++;
          $display("FAIL timeout_data cyc=%0d got=%h want=0", c, res_data);
        end
      end
    end
    exp_terr = 1'b1;
    idle_cycles(2);
    drive_op(2'd2, 32'd50, 32'd8, 2, 0, 1);
  endtask

  task automatic test_reset_mid_op();
    drive_op(2'd1, 32'd4321, 32'd10, 2, 0, 1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_op    = 2'd3;
      req_op1   = 32'd999;
      req_op2   = 32'd13;
      unit_done = 1'b0;
      @(negedge clk);
    end
    #1;
    reset     = 1'b1;
    req_valid = 1'b0;
    #1;
    checks++;
    if ({stall, res_valid, unit_start, unit_abort, unit_signed, timeout_err, res_data, unit_op1, unit_op2} !== '0) begin
      failures++;
      $display("FAIL midop_reset got=%b%b%b%b%b%b %h %h %h", stall, res_valid, unit_start, unit_abort,
               unit_signed, timeout_err, res_data, unit_op1, unit_op2);
    end
    @(posedge clk); #1;
    checks++;
    if ({unit_abort, unit_start, res_valid} !== 3'b000) begin
      failures++;
      $display("FAIL midop_reset_abort got=%b want=000", {unit_abort, unit_start, res_valid});
    end
    @(negedge clk);
    reset    = 1'b0;
    exp_terr = 1'b0;
`ifdef RV32_MC_RESULT_CACHE_EN
    m_cv = 1'b0;
`endif
    idle_cycles(1);
    drive_op(2'd1, 32'd4321, 32'd10, 2, 0, 1);
    drive_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 1);
  endtask

  initial begin
    test_reset();
    test_fast_path();
    test_unit_path();
    test_ack_hold();
    test_back_to_back();
    test_flush();
`ifdef RV32_MC_RESULT_CACHE_EN
    test_cache();
`endif
    test_timeout();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
